// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 streaming convolution engine: FSM states,
// default box-filter coefficient and accumulator sizing.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // round(2^frac / 9): each of the nine taps of a unity-gain box filter
    function automatic int coef_default(input int frac);
        return ((1 << frac) + 4) / 9;
    endfunction

    // Product is PW+CW+1 bits; summing nine of them needs four more
    function automatic int acc_width(input int pw, input int cw);
        return pw + cw + 5;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Single-clock simple dual-port line RAM with registered read; a read and a
// write to the same address in one enabled cycle returns the old contents.
module conv_line_buffer #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rd_data <= mem[rd_addr];
            if (we) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over CH-channel packed pixels with runtime frame
// size, writable signed kernel, valid/ready backpressure and saturating output.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int CH    = 3,
    parameter int PW    = 8,
    parameter int CW    = 18,
    parameter int FRAC  = 15,
    parameter int MAX_W = 1024,
    parameter int MAX_H = 1024
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [$clog2(MAX_W+1)-1:0]   img_w,
    input  logic [$clog2(MAX_H+1)-1:0]   img_h,
    input  logic                         coef_we,
    input  logic [3:0]                   coef_addr,
    input  logic signed [CW-1:0]         coef_data,
    input  logic [CH*PW-1:0]             s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [CH*PW-1:0]             m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_user,
    output logic                         m_last,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err
);

    localparam int WW     = $clog2(MAX_W+1);
    localparam int HW     = $clog2(MAX_H+1);
    localparam int AW     = $clog2(MAX_W);
    localparam int DW     = CH*PW;
    localparam int PROD_W = PW+CW+1;
    localparam int ACC_W  = acc_width(PW, CW);

    state_t                state;
    logic [WW-1:0]         w_reg, col;
    logic [HW-1:0]         h_reg, row;
    logic signed [CW-1:0]  coef_reg [9];
    logic                  en, xfer, dims_ok, col_end, row_end;
    logic [AW-1:0]         col_next;
    logic [DW-1:0]         lb0_q, lb1_q;
    logic [DW-1:0]         win_reg [9];
    logic                  v1_reg, user1_reg, last1_reg;
    logic                  v2_reg, user2_reg, last2_reg;
    logic [DW-1:0]         sat_bus;

    assign en       = !m_valid || m_ready;
    assign s_ready  = (state == ST_RUN) && en;
    assign xfer     = s_valid && s_ready;
    assign col_end  = (col == w_reg - 1'b1);
    assign row_end  = (row == h_reg - 1'b1);
    assign dims_ok  = (img_w >= WW'(3)) && (img_w <= WW'(MAX_W)) &&
                      (img_h >= HW'(3)) && (img_h <= HW'(MAX_H));
    // Read port is pre-addressed with the column of the next input so the
    // line-buffer words are already on rd_data when that pixel arrives.
    assign col_next = col_end ? '0 : AW'(col + 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            w_reg   <= '0;
            h_reg   <= '0;
            col     <= '0;
            row     <= '0;
            for (int k = 0; k < 9; k++) begin
                coef_reg[k] <= CW'(coef_default(FRAC));
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (coef_we && coef_addr <= 4'd8) begin
                        coef_reg[coef_addr] <= coef_data;
                    end
                    if (start) begin
                        if (dims_ok) begin
                            state   <= ST_RUN;
                            busy    <= 1'b1;
                            cfg_err <= 1'b0;
                            w_reg   <= img_w;
                            h_reg   <= img_h;
                            col     <= '0;
                            row     <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        if (col_end) begin
                            col <= '0;
                            row <= row + 1'b1;
                            if (row_end) begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (m_valid && m_ready && m_last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // lb0 holds row r-1, lb1 holds row r-2 (fed from lb0's outgoing word)
    conv_line_buffer #(.DEPTH(MAX_W), .WIDTH(DW)) u_lb0 (
        .clk     (clk),
        .en      (xfer),
        .we      (xfer),
        .wr_addr (col[AW-1:0]),
        .wr_data (s_data),
        .rd_addr (col_next),
        .rd_data (lb0_q)
    );

    conv_line_buffer #(.DEPTH(MAX_W), .WIDTH(DW)) u_lb1 (
        .clk     (clk),
        .en      (xfer),
        .we      (xfer),
        .wr_addr (col[AW-1:0]),
        .wr_data (lb0_q),
        .rd_addr (col_next),
        .rd_data (lb1_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 9; k++) begin
                win_reg[k] <= '0;
            end
            {v1_reg, user1_reg, last1_reg} <= '0;
            {v2_reg, user2_reg, last2_reg} <= '0;
            m_valid <= 1'b0;
            m_user  <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
        end else if (en) begin
            if (xfer) begin
                for (int r = 0; r < 3; r++) begin
                    win_reg[r*3]   <= win_reg[r*3+1];
                    win_reg[r*3+1] <= win_reg[r*3+2];
                end
                win_reg[2] <= lb1_q;
                win_reg[5] <= lb0_q;
                win_reg[8] <= s_data;
            end
            v1_reg    <= xfer && (row >= HW'(2)) && (col >= WW'(2));
            user1_reg <= xfer && (row == HW'(2)) && (col == WW'(2));
            last1_reg <= xfer && row_end && col_end;
            v2_reg    <= v1_reg;
            user2_reg <= user1_reg;
            last2_reg <= last1_reg;
            m_valid   <= v2_reg;
            m_user    <= user2_reg;
            m_last    <= last2_reg;
            m_data    <= sat_bus;
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic signed [PROD_W-1:0] prod_reg [9];
        logic signed [ACC_W-1:0]  acc, rnd;
        logic [PW-1:0]            sat;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 0; k < 9; k++) begin
                    prod_reg[k] <= '0;
                end
            end else if (en) begin
                for (int k = 0; k < 9; k++) begin
                    prod_reg[k] <= PROD_W'($signed({1'b0, win_reg[k][gi*PW +: PW]})) *
                                   PROD_W'(coef_reg[k]);
                end
            end
        end

        always_comb begin
            acc = '0;
            for (int k = 0; k < 9; k++) begin
                acc = acc + ACC_W'(prod_reg[k]);
            end
            rnd = (acc + (ACC_W'(1) <<< (FRAC-1))) >>> FRAC;
            if (rnd[ACC_W-1]) begin
                sat = '0;
            end else if (|rnd[ACC_W-2:PW]) begin
                sat = '1;
            end else begin
                sat = rnd[PW-1:0];
            end
        end

        assign sat_bus[gi*PW +: PW] = sat;
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream: random frames and kernels compared
// against a direct valid-mode convolution model, plus control-path scenarios.
module tb_conv3x3_stream;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] img_w = '0;
    logic [10:0] img_h = '0;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [17:0] coef_data = '0;
    logic [23:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_user, m_last, busy, done, cfg_err;

    conv3x3_stream dut (
        .clk(clk), .reset_n(reset_n), .start(start), .img_w(img_w), .img_h(img_h),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_user(m_user), .m_last(m_last), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] d;
        logic        u;
        logic        l;
    } out_t;

    int          checks = 0;
    int          errors = 0;
    longint      model_coef [9];
    logic [23:0] pix_mem [2048];
    out_t        exp_q [$];
    logic [23:0] got_q [$];

    task automatic model_default();
        for (int k = 0; k < 9; k++) model_coef[k] = 64'sh0E39;
    endtask

    // Direct valid-mode 3x3 convolution of the frame in pix_mem
    task automatic build_expected(input int w, input int h);
        out_t e;
        exp_q.delete();
        for (int i = 0; i <= h - 3; i++) begin
            for (int j = 0; j <= w - 3; j++) begin
                for (int ch = 0; ch < 3; ch++) begin
                    longint acc, res;
                    acc = 0;
                    for (int a = 0; a < 3; a++)
                        for (int b = 0; b < 3; b++)
                            acc += longint'(pix_mem[(i+a)*w + (j+b)][ch*8 +: 8]) * model_coef[a*3+b];
                    res = (acc + 16384) >>> 15;
                    if (res < 0) res = 0;
                    else if (res > 255) res = 255;
                    e.d[ch*8 +: 8] = res[7:0];
                end
                e.u = (i == 0) && (j == 0);
                e.l = (i == h - 3) && (j == w - 3);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic write_coef(input int addr, input logic [17:0] data);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 4'(addr); coef_data = data;
        @(negedge clk);
        coef_we = 1'b0;
        if (addr <= 8) model_coef[addr] = longint'($signed(data));
    endtask

    task automatic do_start(input int w, input int h);
        @(negedge clk);
        start = 1'b1; img_w = 11'(w); img_h = 11'(h);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input int w, input int h, input bit stall, input bit disturb);
        int idx, n_out, cyc, n_in;
        bit in_x, out_hs, was_stalled, fin, disturbed;
        logic [23:0] held;
        build_expected(w, h);
        got_q.delete();
        do_start(w, h);
        checks++;
        if (busy !== 1'b1 || cfg_err !== 1'b0) begin
            errors++; $display("FAIL start_%0dx%0d busy=%b cfg_err=%b expected busy=1 cfg_err=0", w, h, busy, cfg_err);
        end
        n_in = w * h; idx = 0; n_out = 0; cyc = 0;
        fin = 0; was_stalled = 0; disturbed = 0; held = '0;
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            if (was_stalled) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== held) begin
                    errors++; $display("FAIL stall_hold valid=%b data=%h expected valid=1 data=%h", m_valid, m_data, held);
                end
            end
            start = 1'b0; coef_we = 1'b0;
            s_valid = (idx < n_in) && (!stall || $urandom_range(0, 2) != 0);
            s_data  = pix_mem[(idx < n_in) ? idx : 0];
            m_ready = !stall || ($urandom_range(0, 1) == 1);
            if (disturb && !disturbed && idx == 5) begin
                start = 1'b1; img_w = 11'd3; img_h = 11'd3;
                coef_we = 1'b1; coef_addr = 4'd4; coef_data = 18'h0;
                disturbed = 1;
            end
            #1;
            in_x = s_valid && s_ready;
            out_hs = m_valid && m_ready;
            was_stalled = m_valid && !m_ready;
            held = m_data;
            if (out_hs) begin
                checks++;
                if (n_out >= exp_q.size()) begin
                    errors++; $display("FAIL extra_output n=%0d data=%h expected no output", n_out, m_data);
                end else begin
                    $display("frame %0dx%0d out[%0d] data=%h user=%b last=%b", w, h, n_out, m_data, m_user, m_last);
                    if (m_data !== exp_q[n_out].d || m_user !== exp_q[n_out].u || m_last !== exp_q[n_out].l) begin
                        errors++;
                        $display("FAIL out[%0d] data=%h user=%b last=%b expected data=%h user=%b last=%b",
                                 n_out, m_data, m_user, m_last, exp_q[n_out].d, exp_q[n_out].u, exp_q[n_out].l);
                    end
                end
                got_q.push_back(m_data);
                n_out++;
                if (n_out == exp_q.size()) fin = 1;
            end
            @(posedge clk);
            if (in_x) idx++;
            cyc++;
        end
        start = 1'b0; coef_we = 1'b0;
        checks++;
        if (!fin || idx != n_in) begin
            errors++; $display("FAIL frame_timeout outputs=%0d inputs=%0d expected outputs=%0d inputs=%0d", n_out, idx, exp_q.size(), n_in);
        end
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL done_pulse done=%b busy=%b expected done=1 busy=0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL done_clear done=%b m_valid=%b expected 0 0", done, m_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if ({m_valid, m_user, m_last, busy, done, cfg_err, s_ready} !== 7'b0 || m_data !== 24'h0) begin
            errors++; $display("FAIL reset_outputs flags=%b data=%h expected 0", {m_valid, m_user, m_last, busy, done, cfg_err, s_ready}, m_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_default();
    endtask

    task automatic test_default_coefs();
        for (int i = 0; i < 20; i++) pix_mem[i] = {8'd90, 8'd90, 8'd90};
        run_frame(5, 4, 0, 0);
    endtask

    task automatic test_identity();
        for (int k = 0; k < 9; k++) write_coef(k, (k == 4) ? 18'h08000 : 18'h0);
        write_coef(9, 18'h01234);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 6; c++) begin
                logic [7:0] v;
                v = 8'(r * 16 + c);
                pix_mem[r*6+c] = {v, v, v};
            end
        run_frame(6, 5, 0, 0);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 9; k++) write_coef(k, 18'h07FFF);
        for (int i = 0; i < 12; i++) pix_mem[i] = 24'hFFFFFF;
        run_frame(4, 3, 0, 0);
        for (int k = 0; k < 9; k++) write_coef(k, (k == 4) ? 18'h38000 : 18'h0);
        for (int i = 0; i < 12; i++) pix_mem[i] = {8'd200, 8'd200, 8'd200};
        run_frame(3, 4, 0, 0);
    endtask

    task automatic test_random_kernel();
        for (int k = 0; k < 9; k++) write_coef(k, 18'($urandom_range(0, 8000)) - 18'd2000);
        for (int i = 0; i < 35; i++) pix_mem[i] = 24'($urandom);
        run_frame(7, 5, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [23:0] ref_q [$];
        for (int i = 0; i < 48; i++) pix_mem[i] = 24'($urandom);
        run_frame(8, 6, 0, 0);
        ref_q = got_q;
        run_frame(8, 6, 1, 0);
        checks++;
        if (got_q.size() != ref_q.size()) begin
            errors++; $display("FAIL stall_count got=%0d expected=%0d", got_q.size(), ref_q.size());
        end else begin
            for (int i = 0; i < ref_q.size(); i++) begin
                checks++;
                if (got_q[i] !== ref_q[i]) begin
                    errors++; $display("FAIL stall_vs_nostall[%0d] got=%h expected=%h", i, got_q[i], ref_q[i]);
                end
            end
        end
    endtask

    task automatic test_control();
        do_start(2, 5);
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bad_dims cfg_err=%b busy=%b expected cfg_err=1 busy=0", cfg_err, busy);
        end
        for (int i = 0; i < 15; i++) pix_mem[i] = 24'($urandom);
        run_frame(5, 3, 0, 1);
    endtask

    task automatic test_w3h3();
        for (int i = 0; i < 9; i++) pix_mem[i] = 24'($urandom);
        run_frame(3, 3, 1, 0);
    endtask

    task automatic test_reset_midframe();
        int n, cyc;
        bit x;
        for (int i = 0; i < 20; i++) pix_mem[i] = 24'($urandom);
        do_start(5, 4);
        n = 0; cyc = 0;
        while (n < 10 && cyc < 200) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = pix_mem[n]; m_ready = 1'b1;
            #1;
            x = s_ready;
            @(posedge clk);
            if (x) n++;
            cyc++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b0 || n != 10) begin
            errors++; $display("FAIL abort busy=%b m_valid=%b s_ready=%b fed=%0d expected 0 0 0 10", busy, m_valid, s_ready, n);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_default();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL post_abort done=%b busy=%b expected 0 0", done, busy);
            end
        end
        for (int i = 0; i < 12; i++) pix_mem[i] = 24'($urandom);
        run_frame(4, 3, 0, 0);
    endtask

    initial begin
        test_reset();
        test_default_coefs();
        test_identity();
        test_saturation();
        test_random_kernel();
        test_back_to_back();
        test_control();
        test_w3h3();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
